rc_cmp_monitor: RTL and testbench

RC_CMP_MONITOR -- requirements
Module: rc_cmp_monitor

---
 rtl/rc_cmp_monitor.sv | 181 ++++++++++++++++++
 tb/tb_rc_cmp_monitor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rc_cmp_monitor.sv
// Compares N_CH model channels against a reference sample each cycle, with a
// settle window after enable, persistence filtering and sticky failure reporting.

module rc_cmp_lane #(
  parameter int WIDTH   = 16,
  parameter int TOL     = 1,
  parameter int PERSIST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_chk,
  input  logic [WIDTH-1:0] i_dut,
  input  logic [WIDTH-1:0] i_ref,
  output logic [WIDTH:0]   o_abs,
  output logic             o_viol,
  output logic             o_err,
  output logic             o_fail
);
  localparam int             RW      = $clog2(PERSIST + 1);
  localparam logic [RW-1:0]  RUN_MAX = RW'(PERSIST);
  localparam logic [WIDTH:0] TOL_V   = (WIDTH + 1)'(TOL);

  logic [WIDTH:0]  w_diff;
  logic [RW-1:0]   w_run_inc;
  logic [RW-1:0]   r_run;
  logic            r_err;
  logic            r_fail;

  // One extra bit keeps the full signed range of the difference
  assign w_diff    = {i_dut[WIDTH-1], i_dut} - {i_ref[WIDTH-1], i_ref};
  assign o_abs     = w_diff[WIDTH] ? (~w_diff + 1'b1) : w_diff;
  assign o_viol    = o_abs > TOL_V;
  assign w_run_inc = (r_run == RUN_MAX) ? r_run : r_run + 1'b1;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_run  <= '0;
      r_err  <= 1'b0;
      r_fail <= 1'b0;
    end else begin
      r_err <= i_chk && o_viol;
      if (!i_en) begin
        r_run <= '0;
      end else if (i_chk) begin
        r_run <= o_viol ? w_run_inc : '0;
        if (o_viol && w_run_inc == RUN_MAX) r_fail <= 1'b1;
      end
    end
  end

  assign o_err  = r_err;
  assign o_fail = r_fail;
endmodule

module rc_cmp_monitor #(
  parameter  int N_CH          = 2,
  parameter  int WIDTH         = 16,
  parameter  int TOL           = 1,
  parameter  int SETTLE_CYCLES = 4,
  parameter  int PERSIST       = 1,
  parameter  int CNT_WIDTH     = 16,
  localparam int MCH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clear,
  input  logic [WIDTH-1:0]      ref_in,
  input  logic [N_CH*WIDTH-1:0] dut_in,
  output logic [N_CH-1:0]       ch_err,
  output logic [N_CH-1:0]       ch_fail,
  output logic                  fail,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [WIDTH:0]        max_diff,
  output logic [MCH_W-1:0]      max_ch,
  output logic [1:0]            state
);
  localparam int SC_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETTLE = 2'd1, S_CHECK = 2'd2} state_t;

  state_t                      r_state, w_state_nxt;
  logic [SC_W-1:0]             r_scnt, w_scnt_nxt;
  logic                        w_chk;
  logic [N_CH-1:0][WIDTH:0]    w_abs;
  logic [N_CH-1:0]             w_viol;
  logic [WIDTH:0]              w_best;
  logic [MCH_W-1:0]            w_best_ch;
  logic [CNT_WIDTH-1:0]        r_cnt;
  logic [WIDTH:0]              r_max;
  logic [MCH_W-1:0]            r_max_ch;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_scnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_scnt  <= w_scnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_scnt_nxt  = r_scnt;
    if (!en) begin
      w_state_nxt = S_IDLE;
      w_scnt_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
          w_scnt_nxt  = SC_W'(SETTLE_CYCLES);
        end
        S_SETTLE: begin
          if (r_scnt <= SC_W'(1)) begin
            w_state_nxt = S_CHECK;
            w_scnt_nxt  = '0;
          end else begin
            w_scnt_nxt  = r_scnt - 1'b1;
          end
        end
        S_CHECK: w_state_nxt = S_CHECK;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // A sample is only judged while checking and still enabled
  assign w_chk = (r_state == S_CHECK) && en;

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    rc_cmp_lane #(.WIDTH(WIDTH), .TOL(TOL), .PERSIST(PERSIST)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (clear),
      .i_en   (en),
      .i_chk  (w_chk),
      .i_dut  (dut_in[k*WIDTH +: WIDTH]),
      .i_ref  (ref_in),
      .o_abs  (w_abs[k]),
      .o_viol (w_viol[k]),
      .o_err  (ch_err[k]),
      .o_fail (ch_fail[k])
    );
  end

  // Strict compare keeps the lowest channel on ties
  always_comb begin
    w_best    = '0;
    w_best_ch = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_abs[k] > w_best) begin
        w_best    = w_abs[k];
        w_best_ch = MCH_W'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt    <= '0;
      r_max    <= '0;
      r_max_ch <= '0;
    end else if (w_chk) begin
      if (|w_viol && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      if (w_best > r_max) begin
        r_max    <= w_best;
        r_max_ch <= w_best_ch;
      end
    end
  end

  assign fail      = |ch_fail;
  assign err_count = r_cnt;
  assign max_diff  = r_max;
  assign max_ch    = r_max_ch;
  assign state     = r_state;
endmodule

// File: tb/tb_rc_cmp_monitor.sv
// Scoreboard bench for rc_cmp_monitor: a behavioural model queues expected
// outputs per driven cycle; directed checks cover the key corner cases.

module tb_rc_cmp_monitor;
  localparam int N_CH = 2, WIDTH = 16, TOL = 4, SC = 3, PERSIST = 2, CW = 16;

  logic                  clk = 1'b0;
  logic                  rst, en, clear;
  logic signed [15:0]    ref_in;
  logic [31:0]           dut_in;
  logic [1:0]            ch_err, ch_fail;
  logic                  fail;
  logic [15:0]           err_count;
  logic [16:0]           max_diff;
  logic                  max_ch;
  logic [1:0]            state;

  rc_cmp_monitor #(.N_CH(N_CH), .WIDTH(WIDTH), .TOL(TOL), .SETTLE_CYCLES(SC),
                   .PERSIST(PERSIST), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .ref_in(ref_in), .dut_in(dut_in),
    .ch_err(ch_err), .ch_fail(ch_fail), .fail(fail), .err_count(err_count),
    .max_diff(max_diff), .max_ch(max_ch), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [1:0]  err;
    logic [1:0]  fl;
    logic        f;
    logic [15:0] cnt;
    logic [16:0] mx;
    logic        mch;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_err = 0;

  int         m_state = 0, m_scnt = 0, m_cnt = 0, m_max = 0, m_maxch = 0;
  int         m_run[2] = '{0, 0};
  logic [1:0] m_err = 2'b00, m_fail = 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic c,
                      input int rf, input int d0, input int d1);
    exp_t x;
    int   a[2];
    int   best, bi;
    bit   chk, anyv, v;
    rst = r; en = e; clear = c;
    ref_in = 16'(rf);
    dut_in = {16'(d1), 16'(d0)};
    chk = (m_state == 2) && e;
    a[0] = d0 - rf; if (a[0] < 0) a[0] = -a[0];
    a[1] = d1 - rf; if (a[1] < 0) a[1] = -a[1];
    if (r) begin
      m_state = 0; m_scnt = 0; m_cnt = 0; m_max = 0; m_maxch = 0;
      m_run = '{0, 0}; m_err = 0; m_fail = 0;
    end else begin
      if (c) begin
        m_err = 0; m_fail = 0; m_cnt = 0; m_max = 0; m_maxch = 0; m_run = '{0, 0};
      end else begin
        anyv = 0;
        for (int k = 0; k < 2; k++) begin
          v = chk && (a[k] > TOL);
          m_err[k] = v;
          anyv |= v;
          if (!e) m_run[k] = 0;
          else if (chk) begin
            if (v) begin
              if (m_run[k] < PERSIST) m_run[k]++;
              if (m_run[k] >= PERSIST) m_fail[k] = 1'b1;
            end else m_run[k] = 0;
          end
        end
        if (anyv && m_cnt < 65535) m_cnt++;
        if (chk) begin
          best = -1; bi = 0;
          for (int k = 0; k < 2; k++) if (a[k] > best) begin best = a[k]; bi = k; end
          if (best > m_max) begin m_max = best; m_maxch = bi; end
        end
      end
      if (!e) begin m_state = 0; m_scnt = 0; end
      else case (m_state)
        0: begin m_state = (SC == 0) ? 2 : 1; m_scnt = SC; end
        1: if (m_scnt <= 1) begin m_state = 2; m_scnt = 0; end else m_scnt--;
        default: ;
      endcase
    end
    x.st = 2'(m_state); x.err = m_err; x.fl = m_fail; x.f = |m_fail;
    x.cnt = 16'(m_cnt); x.mx = 17'(m_max); x.mch = 1'(m_maxch);
    q.push_back(x);
    @(posedge clk);
    #1;
    x = q.pop_front();
    check("sb_state", state, x.st);
    check("sb_ch_err", ch_err, x.err);
    check("sb_ch_fail", ch_fail, x.fl);
    check("sb_fail", fail, x.f);
    check("sb_err_count", err_count, x.cnt);
    check("sb_max_diff", max_diff, x.mx);
    check("sb_max_ch", max_ch, x.mch);
  endtask

  initial begin
    int st_exp[4];
    int rf, d0, d1;
    st_exp = '{1, 1, 1, 2};
    rst = 1; en = 0; clear = 0; ref_in = 0; dut_in = 0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("rst_state", state, 0);
    check("rst_err_count", err_count, 0);

    // settle window hides a gross mismatch
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 100, 0);
      check("settle_state", state, st_exp[i]);
      check("settle_ch_err", ch_err, 0);
      check("settle_err_count", err_count, 0);
    end

    // tolerance boundary
    step(0, 1, 0, 1000, 1004, 995);
    check("tol_edge_ch_err", ch_err, 2'b10);
    step(0, 1, 0, 1000, 1005, 1000);
    check("tol_over_ch_err", ch_err, 2'b01);
    check("tol_err_count", err_count, 2);

    step(0, 1, 1, 0, 0, 0);
    check("clear_err_count", err_count, 0);

    // persistence on channel 1
    step(0, 1, 0, 0, 0, 10);
    check("persist_1_fail", ch_fail, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 10);
    check("persist_3_fail", ch_fail, 0);
    step(0, 1, 0, 0, 0, 10);
    check("persist_4_fail", ch_fail, 2'b10);
    check("persist_fail", fail, 1);
    check("persist_err_count", err_count, 3);

    // extreme operands
    step(0, 1, 0, -32768, 32767, -32768);
    check("extreme_max_diff", max_diff, 65535);
    check("extreme_max_ch", max_ch, 0);

    // clear wins over a violation in the same cycle
    step(0, 1, 1, 0, 50, 0);
    check("clrwin_ch_err", ch_err, 0);
    check("clrwin_ch_fail", ch_fail, 0);
    check("clrwin_err_count", err_count, 0);
    check("clrwin_max_diff", max_diff, 0);

    // max tracking: tie and equal-value behaviour
    step(0, 1, 0, 0, 7, -7);
    check("tie_max_diff", max_diff, 7);
    check("tie_max_ch", max_ch, 0);
    step(0, 1, 0, 0, 3, -9);
    check("new_max_ch", max_ch, 1);
    step(0, 1, 0, 0, 9, 0);
    check("equal_max_ch", max_ch, 1);

    for (int i = 0; i < 40; i++) begin
      rf = int'($urandom_range(40)) - 20;
      d0 = rf + int'($urandom_range(16)) - 8;
      d1 = rf + int'($urandom_range(16)) - 8;
      step(0, 1, ($urandom_range(9) == 0), rf, d0, d1);
    end

    // en drop keeps sticky fail
    step(0, 1, 0, 0, 20, 0);
    step(0, 1, 0, 0, 20, 0);
    check("pre_drop_fail0", ch_fail[0], 1);
    step(0, 0, 0, 0, 0, 0);
    check("drop_state", state, 0);
    check("drop_fail0", ch_fail[0], 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 0, 0);
      check("reen_state", state, st_exp[i]);
    end
    step(0, 1, 0, 0, 20, 0);
    check("recheck_ch_err", ch_err, 2'b01);

    // reset mid-CHECK, then a full settle again
    step(1, 1, 0, 0, 20, 20);
    check("midrst_state", state, 0);
    check("midrst_ch_fail", ch_fail, 0);
    check("midrst_ch_err", ch_err, 0);
    check("midrst_err_count", err_count, 0);
    check("midrst_max_diff", max_diff, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 20, 20);
      check("post_rst_state", state, st_exp[i]);
      check("post_rst_ch_err", ch_err, 0);
    end
    step(0, 1, 0, 0, 20, 20);
    check("post_rst_check", ch_err, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
